parking_gate_ctrl: RTL

//   Parametrised parking-lot occupancy controller with independent entry/exit barrier FSMs.

---
 rtl/parking_gate_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: parking-lot occupancy controller with independent
// entry and exit barrier FSMs (IDLE -> OPEN -> PASS -> IDLE), a per-gate
// open timeout, and registered full/empty/almost_full status.
// Optional feature macro: PARK_STATS_EN adds committed-entry/exit totals.
module parking_gate_ctrl #(
  parameter int CAPACITY      = 10,
  parameter int CNT_W         = 8,
  parameter int ALMOST_MARGIN = 2,
  parameter int TIMEOUT_CYC   = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             entry_req,
  input  logic             entry_pass,
  input  logic             exit_req,
  input  logic             exit_pass,
  output logic             entry_open,
  output logic             exit_open,
  output logic             entry_denied,
  output logic [1:0]       gate_timeout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             almost_full
`ifdef PARK_STATS_EN
  ,
  output logic [15:0]      total_in,
  output logic [15:0]      total_out
`endif
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CAP_VAL    = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] ALMOST_VAL = CNT_W'(CAPACITY - ALMOST_MARGIN);

  typedef enum logic [1:0] {ST_IDLE, ST_OPEN, ST_PASS} gate_state_t;

  // Index 0 is the entry gate, index 1 the exit gate.
  logic [1:0] req_vec;
  logic [1:0] pass_vec;
  logic [1:0] grant_ok;
  logic [1:0] open_vec;
  logic [1:0] timeout_vec;
  logic [1:0] commit_vec;
  logic [1:0] idle_vec;

  logic [CNT_W-1:0] count_reg, count_next;
  logic             full_reg, empty_reg, almost_reg;
  logic             denied_reg, armed_reg, deny_fire;
  logic             entry_eff, exit_eff;

  assign req_vec  = {exit_req, entry_req};
  assign pass_vec = {exit_pass, entry_pass};
  // Entry needs a free slot, exit needs at least one parked car.
  assign grant_ok = {!empty_reg, !full_reg};

  for (genvar gi = 0; gi < 2; gi++) begin : g_gate
    gate_state_t      state_reg, state_next;
    logic [TMR_W-1:0] timer_reg, timer_next;
    logic             open_reg, timeout_reg, timeout_next, commit;

    // Gate next-state, timer, timeout pulse and commit strobe.
    always_comb begin
      state_next   = state_reg;
      timer_next   = timer_reg;
      timeout_next = 1'b0;
      commit       = 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (req_vec[gi] && grant_ok[gi]) begin
            state_next = ST_OPEN;
            timer_next = '0;
          end
        end
        ST_OPEN: begin
          if (pass_vec[gi]) begin
            state_next = ST_PASS;
            timer_next = '0;
          end else if (timer_reg == TMR_LAST) begin
            state_next   = ST_IDLE;
            timer_next   = '0;
            timeout_next = 1'b1;
          end else begin
            timer_next = timer_reg + TMR_W'(1);
          end
        end
        ST_PASS: begin
          if (!pass_vec[gi]) begin
            state_next = ST_IDLE;
            commit     = 1'b1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end

    // Gate state register; barrier command follows the next state so it is registered.
    always_ff @(posedge clk) begin
      if (reset) begin
        state_reg   <= ST_IDLE;
        timer_reg   <= '0;
        open_reg    <= 1'b0;
        timeout_reg <= 1'b0;
      end else begin
        state_reg   <= state_next;
        timer_reg   <= timer_next;
        open_reg    <= (state_next != ST_IDLE);
        timeout_reg <= timeout_next;
      end
    end

    assign open_vec[gi]    = open_reg;
    assign timeout_vec[gi] = timeout_reg;
    assign commit_vec[gi]  = commit;
    assign idle_vec[gi]    = (state_reg == ST_IDLE);
  end

  // A refused entry pulses once, then waits for the loop to clear before re-arming.
  assign deny_fire = idle_vec[0] && entry_req && full_reg && armed_reg;

  // Denied pulse and its re-arm flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      denied_reg <= 1'b0;
      armed_reg  <= 1'b1;
    end else begin
      denied_reg <= deny_fire;
      if (!entry_req)
        armed_reg <= 1'b1;
      else if (deny_fire)
        armed_reg <= 1'b0;
    end
  end

  // Commits are bounded so the count stays within 0..CAPACITY; a paired commit nets to zero.
  assign entry_eff = commit_vec[0] && ((count_reg < CAP_VAL) || commit_vec[1]);
  assign exit_eff  = commit_vec[1] && ((count_reg != '0) || commit_vec[0]);

  // Next occupancy from this edge's commits.
  always_comb begin
    count_next = count_reg;
    if (entry_eff && !exit_eff)
      count_next = count_reg + CNT_W'(1);
    else if (exit_eff && !entry_eff)
      count_next = count_reg - CNT_W'(1);
  end

  // Occupancy and flags, flags derived from the next count so they are never stale.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg  <= '0;
      empty_reg  <= 1'b1;
      full_reg   <= 1'b0;
      almost_reg <= (ALMOST_MARGIN == CAPACITY);
    end else begin
      count_reg  <= count_next;
      empty_reg  <= (count_next == '0);
      full_reg   <= (count_next == CAP_VAL);
      almost_reg <= (count_next >= ALMOST_VAL);
    end
  end

`ifdef PARK_STATS_EN
  logic [15:0] total_in_reg, total_out_reg;

  // Lifetime committed-car totals, wrapping modulo 2**16.
  always_ff @(posedge clk) begin
    if (reset) begin
      total_in_reg  <= '0;
      total_out_reg <= '0;
    end else begin
      if (entry_eff)
        total_in_reg <= total_in_reg + 16'd1;
      if (exit_eff)
        total_out_reg <= total_out_reg + 16'd1;
    end
  end

  assign total_in  = total_in_reg;
  assign total_out = total_out_reg;
`endif

  assign entry_open   = open_vec[0];
  assign exit_open    = open_vec[1];
  assign entry_denied = denied_reg;
  assign gate_timeout = timeout_vec;
  assign count        = count_reg;
  assign full         = full_reg;
  assign empty        = empty_reg;
  assign almost_full  = almost_reg;

endmodule
